// File: rtl/mem_shadow_model_pkg.sv
// Shared types and helpers for the memory shadow model: FSM encoding and the
// word-address comparator used by every slot.
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_XLEN = 64;
    localparam int XLEN_DEF = 32;
    localparam int STRB_W   = XLEN_DEF / 8;

    // Word compare: byte-offset bits [1:0] never take part in the match.
    function automatic logic word_match(input logic [MAX_XLEN-1:0] a,
                                        input logic [MAX_XLEN-1:0] b,
                                        input int                  xlen);
        logic m;
        m = 1'b1;
        for (int i = 2; i < MAX_XLEN; i++)
            if (i < xlen && a[i] != b[i]) m = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/mem_shadow_model_if.sv
// Core valid/ready memory bus: the core is the master, the shadow model the slave.
interface mem_shadow_model_if #(parameter int XLEN = 32);
    import mem_model_pkg::*;

    logic              mem_valid;
    logic              mem_instr;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_shadow_model_slot.sv
// One tracked shadow word: byte-strobed write on commit, plus match flags
// against the live bus address and the latched request address.
module mem_shadow_slot
    import mem_model_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] INIT_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   slot_addr,
    input  logic [XLEN-1:0]   live_addr,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN/8-1:0] wstrb,
    input  logic              commit,
    output logic [XLEN-1:0]   word,
    output logic              live_match,
    output logic              req_match
);

    always_comb begin
        live_match = word_match(MAX_XLEN'(slot_addr), MAX_XLEN'(live_addr), XLEN);
        req_match  = word_match(MAX_XLEN'(slot_addr), MAX_XLEN'(req_addr), XLEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= INIT_DATA;
        end else if (commit && req_match) begin
            for (int j = 0; j < XLEN/8; j++)
                if (wstrb[j]) word[8*j +: 8] <= wdata[8*j +: 8];
        end
    end

endmodule

// File: rtl/mem_shadow_model.sv
// Memory-side responder with NUM_SLOTS shadow words, bounded latency/stall and
// a sticky requester protocol checker.
module mem_shadow_model
    import mem_model_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_SLOTS = 4,
    parameter int              LATENCY   = 1,
    parameter int              MAX_STALL = 7,
    parameter logic [XLEN-1:0] INIT_DATA = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_shadow_model_if.slave         bus,
    input  logic [NUM_SLOTS*XLEN-1:0] slot_addr,
    input  logic [XLEN-1:0]           ext_rdata,
    input  logic                      stall,
    output logic [NUM_SLOTS-1:0]      slot_hit,
    output logic                      violation
);

    localparam int SW    = XLEN / 8;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [STL_W-1:0] STALL_MAX = STL_W'(MAX_STALL);

    state_t                          state, state_nx;
    logic [LAT_W-1:0]                lat_cnt, lat_nx;
    logic [STL_W-1:0]                stall_cnt, stall_nx;
    logic                            take, commit, proto_err;
    logic [XLEN-1:0]                 addr_q, wdata_q, rd_sel;
    logic [SW-1:0]                   wstrb_q;
    logic                            unused_instr_q;
    logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_word;
    logic [NUM_SLOTS-1:0]            live_match, req_match;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        mem_shadow_slot #(.XLEN(XLEN), .INIT_DATA(INIT_DATA)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .slot_addr  (slot_addr[i*XLEN +: XLEN]),
            .live_addr  (bus.mem_addr),
            .req_addr   (addr_q),
            .wdata      (wdata_q),
            .wstrb      (wstrb_q),
            .commit     (commit),
            .word       (slot_word[i]),
            .live_match (live_match[i]),
            .req_match  (req_match[i])
        );
    end

    assign slot_hit = live_match & {NUM_SLOTS{bus.mem_valid}};

    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        stall_nx = stall_cnt;
        take     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_valid) begin
                    state_nx = WAIT;
                    lat_nx   = LAT_INIT;
                    stall_nx = '0;
                    take     = 1'b1;
                end
            end
            WAIT: begin
                if (lat_cnt != '0) begin
                    lat_nx = lat_cnt - 1'b1;
                end else if (stall && stall_cnt < STALL_MAX) begin
                    stall_nx = stall_cnt + 1'b1;
                end else begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lowest-index matching slot wins; untracked addresses fall through to ext_rdata.
    always_comb begin
        rd_sel = ext_rdata;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (req_match[i]) rd_sel = slot_word[i];
    end

    always_comb begin
        proto_err = (state == WAIT) &&
                    (!bus.mem_valid || bus.mem_addr != addr_q ||
                     bus.mem_wdata != wdata_q || bus.mem_wstrb != wstrb_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            stall_cnt      <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            unused_instr_q <= 1'b0;
            bus.mem_ready  <= 1'b0;
            bus.mem_rdata  <= '0;
            violation      <= 1'b0;
        end else begin
            state     <= state_nx;
            lat_cnt   <= lat_nx;
            stall_cnt <= stall_nx;
            if (take) begin
                addr_q         <= bus.mem_addr;
                wdata_q        <= bus.mem_wdata;
                wstrb_q        <= bus.mem_wstrb;
                unused_instr_q <= bus.mem_instr;
            end
            // Read data is the pre-write word; the slots commit on this same edge.
            bus.mem_ready <= commit;
            if (commit) bus.mem_rdata <= rd_sel;
            if (proto_err) violation <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_shadow_model.sv
// Randomized bench for mem_shadow_model against a slot-array reference model.
module tb_mem_shadow_model;

    localparam int XLEN      = 32;
    localparam int NUM_SLOTS = 4;
    localparam int LATENCY   = 3;
    localparam int MAX_STALL = 7;

    logic                      clk;
    logic                      reset;
    logic [NUM_SLOTS*XLEN-1:0] slot_addr;
    logic [XLEN-1:0]           ext_rdata;
    logic                      stall;
    logic [NUM_SLOTS-1:0]      slot_hit;
    logic                      violation;

    logic [31:0] sa     [NUM_SLOTS];
    logic [31:0] shadow [NUM_SLOTS];
    int n_chk  = 0;
    int n_pass = 0;

    mem_shadow_model_if #(.XLEN(XLEN)) bus ();

    mem_shadow_model #(
        .XLEN(XLEN), .NUM_SLOTS(NUM_SLOTS), .LATENCY(LATENCY),
        .MAX_STALL(MAX_STALL), .INIT_DATA(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .slot_addr(slot_addr),
        .ext_rdata(ext_rdata), .stall(stall), .slot_hit(slot_hit),
        .violation(violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        slot_addr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) slot_addr[i*XLEN +: XLEN] = sa[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit hits(input logic [31:0] a, input int i);
        return a[31:2] == sa[i][31:2];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] ext);
        for (int i = 0; i < NUM_SLOTS; i++)
            if (hits(a, i)) return shadow[i];
        return ext;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) shadow[i] = 32'h0;
    endtask

    // One request; stall is held for ns cycles once the base latency has elapsed.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int ns, input logic [31:0] ext);
        logic [31:0] exp_rd;
        logic [3:0]  exp_hit;
        int exp_lat, got;
        exp_rd  = model_read(a, ext);
        exp_lat = LATENCY + ((ns < MAX_STALL) ? ns : MAX_STALL);
        exp_hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) exp_hit[i] = hits(a, i);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'($urandom);
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        ext_rdata     = ext;
        stall         = 1'b1;
        #1 chk({tag, "_hit"}, 32'(slot_hit), 32'(exp_hit));
        @(posedge clk);
        got = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.mem_ready) begin
                got = k;
                break;
            end
            if (k >= LATENCY + ns - 1) stall = 1'b0;
            @(posedge clk);
        end
        chk({tag, "_lat"}, 32'(got), 32'(exp_lat));
        if (ws == 4'h0) chk({tag, "_rdata"}, bus.mem_rdata, exp_rd);
        bus.mem_valid = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (hits(a, i))
                for (int j = 0; j < 4; j++)
                    if (ws[j]) shadow[i][8*j +: 8] = wd[8*j +: 8];
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 32'(bus.mem_ready), 32'd0);
    endtask

    // mode 0: drop mem_valid for one WAIT cycle; mode 1: change mem_addr for one cycle.
    task automatic viol_req(input string tag, input int mode);
        int got;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h100;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        if (mode == 0) bus.mem_valid = 1'b0;
        else bus.mem_addr = 32'h300;
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h100;
        chk({tag, "_set"}, 32'(violation), 32'd1);
        got = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_ready) begin
                got = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_resp"}, 32'(got >= 0), 32'd1);
        chk({tag, "_rdata"}, bus.mem_rdata, shadow[0]);
        bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk({tag, "_sticky"}, 32'(violation), 32'd1);
    endtask

    initial begin
        logic [31:0] bases [6];
        logic [31:0] a;
        logic [3:0]  ws;
        int          rise;

        sa[0] = 32'h100; sa[1] = 32'h40; sa[2] = 32'h40; sa[3] = 32'h300;
        bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0;   bus.mem_wstrb = '0;   ext_rdata = '0;
        stall = 1'b0;
        do_reset();
        #1;
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        chk("rst_viol", 32'(violation), 32'd0);

        do_req("rd_init", 32'h100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
        do_req("wr_part", 32'h100, 32'hAABB_CCDD, 4'b0101, 0, 32'h0);
        do_req("rd_part", 32'h100, 32'h0, 4'h0, 0, 32'h0);
        chk("part_val", shadow[0], 32'h00BB_00DD);
        do_req("stall_max", 32'h100, 32'h0, 4'h0, 20, 32'h0);
        do_req("stall_2", 32'h100, 32'h0, 4'h0, 2, 32'h0);
        do_req("untracked", 32'h200, 32'h0, 4'h0, 0, 32'h1234_5678);
        do_req("rd_after_ut", 32'h100, 32'h0, 4'h0, 0, 32'h0);

        do_req("wr_dup", 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
        do_req("rd_dup", 32'h40, 32'h0, 4'h0, 0, 32'h0);
        sa[1] = 32'h80;
        do_req("rd_slot2", 32'h40, 32'h0, 4'h0, 0, 32'h0);
        do_req("wr_slot2", 32'h40, 32'h1111_1111, 4'hF, 0, 32'h0);
        sa[1] = 32'h40;
        do_req("rd_prio", 32'h40, 32'h0, 4'h0, 0, 32'h0);

        bases[0] = sa[0]; bases[1] = sa[1]; bases[2] = 32'h80; bases[3] = sa[3];
        bases[4] = 32'h200; bases[5] = 32'h500;
        for (int n = 0; n < 60; n++) begin
            a  = bases[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            ws = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            if (n % 10 == 0) sa[2] = ($urandom_range(0, 1) != 0) ? 32'h80 : 32'h40;
            do_req("rand", a, $urandom, ws, int'($urandom_range(0, 9)), $urandom);
        end
        chk("rand_viol", 32'(violation), 32'd0);

        viol_req("viol_valid", 0);
        do_reset();
        #1 chk("viol_cleared", 32'(violation), 32'd0);
        do_req("pre_addr", 32'h100, 32'hCAFE_F00D, 4'hF, 0, 32'h0);
        viol_req("viol_addr", 1);

        // Reset while in WAIT: pending write dropped, outputs back to reset values.
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h100;
        bus.mem_wdata = 32'h5555_5555;
        bus.mem_wstrb = 4'hF;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rstw_ready", 32'(bus.mem_ready), 32'd0);
        chk("rstw_rdata", bus.mem_rdata, 32'h0);
        chk("rstw_viol", 32'(violation), 32'd0);
        rise = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.mem_ready) rise = 1;
        end
        chk("rstw_noready", 32'(rise), 32'd0);
        bus.mem_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) shadow[i] = 32'h0;
        do_req("rstw_lost", 32'h100, 32'h0, 4'h0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
